// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared types for the ibus/dbus memory arbiter
// Rev 1.0 : initial release
// ============================================================================
package arb_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } arb_owner_e;

  typedef struct packed {
    logic                  is_write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [ARB_STRB_W-1:0] strobe;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_latch_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory bus between ibus and dbus, dbus priority
//               with a bounded-wait rule so fetch cannot starve
// Rev 1.0 : initial release
// ============================================================================
import arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic              m_is_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        owner
);

  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  mem_req_latch_t    req_q, req_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        // dbus wins unless fetch has already lost MAX_WAIT times in a row
        if (d_valid && (!i_valid || (wait_cnt_q != WAIT_MAX))) begin
          state_d        = GRANT_D;
          req_d.is_write = |d_strobe;
          req_d.addr     = ARB_ADDR_W'(d_addr);
          req_d.size     = d_size;
          req_d.strobe   = ARB_STRB_W'(d_strobe);
          req_d.wdata    = ARB_DATA_W'(d_wdata);
          // the guard above keeps this below WAIT_MAX, so it saturates
          if (i_valid) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else if (i_valid) begin
          state_d    = GRANT_I;
          req_d      = '0;
          req_d.addr = ARB_ADDR_W'(i_addr);
          req_d.size = i_size;
          wait_cnt_d = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (m_ready) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    m_valid    = (state_q == GRANT_I) || (state_q == GRANT_D);
    m_is_write = req_q.is_write;
    m_addr     = ADDR_W'(req_q.addr);
    m_size     = req_q.size;
    m_strobe   = (DATA_W/8)'(req_q.strobe);
    m_wdata    = DATA_W'(req_q.wdata);
    i_ready    = (state_q == GRANT_I) && m_ready;
    d_ready    = (state_q == GRANT_D) && m_ready;
    i_data     = i_ready ? m_rdata : '0;
    d_rdata    = d_ready ? m_rdata : '0;
    case (state_q)
      GRANT_I: owner = OWNER_I;
      GRANT_D: owner = OWNER_D;
      default: owner = OWNER_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : randomized scoreboard bench for mem_arbiter
// Rev 1.0 : initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int SW       = DATA_W / 8;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [2:0]        i_size;
  logic [DATA_W-1:0] i_data;
  logic              d_valid, d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [SW-1:0]     d_strobe;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              m_valid, m_is_write, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [SW-1:0]     m_strobe;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [1:0]        owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_size(i_size), .i_ready(i_ready), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_size(m_size),
    .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
    .owner(owner)
  );

  // One expected memory access: grant cycle g, response cycle r
  typedef struct {
    int          g;
    int          r;
    logic [1:0]  who;
    logic        w;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } acc_t;

  acc_t       acc_q[$];
  logic [1:0] hold_log[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int next_arb = 0, losses = 0, cur_g = -1, cur_r = -1;
  logic [63:0] cur_rdata;
  int mode = 2;  // 0 random, 1 both held, 2 idle, 3 dbus only

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle: drive inputs, then apply the arbitration rules
  task automatic step(input bit assert_rst);
    acc_t a;
    int   lat;
    @(posedge clk);
    #1;
    cyc++;
    rst = assert_rst;
    if (rst) begin
      acc_q.delete();
      cur_g = -1; cur_r = -1;
      next_arb = cyc + 1;
      losses = 0;
    end
    case (mode)
      0: begin
        if ($urandom_range(0, 1) == 1) begin
          i_valid = ($urandom_range(0, 9) < 6);
          i_addr  = {$urandom, $urandom};
          i_size  = 3'($urandom);
        end
        if ($urandom_range(0, 1) == 1) begin
          d_valid  = ($urandom_range(0, 9) < 6);
          d_addr   = {$urandom, $urandom};
          d_size   = 3'($urandom);
          d_strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
          d_wdata  = {$urandom, $urandom};
        end
      end
      1: begin i_valid = 1'b1; d_valid = 1'b1; end
      3: begin
        i_valid = 1'b0; d_valid = 1'b1;
        d_addr = {$urandom, $urandom}; d_strobe = 8'h0F; d_wdata = {$urandom, $urandom};
      end
      default: begin i_valid = 1'b0; d_valid = 1'b0; end
    endcase
    if (cyc == cur_r) begin
      m_ready = 1'b1; m_rdata = cur_rdata;
    end else if (cyc > cur_g && cyc < cur_r) begin
      m_ready = 1'b0; m_rdata = {$urandom, $urandom};
    end else begin
      m_ready = ($urandom_range(0, 3) == 0); m_rdata = {$urandom, $urandom};
    end
    if (!rst && cyc >= next_arb) begin
      a.who = 2'd0;
      if (d_valid && (!i_valid || losses != MAX_WAIT)) begin
        a.who = 2'd2;
        if (i_valid) losses++;
        a.w = (d_strobe != 0); a.addr = d_addr; a.size = d_size;
        a.strb = d_strobe; a.wdata = d_wdata;
      end else if (i_valid) begin
        a.who = 2'd1;
        losses = 0;
        a.w = 1'b0; a.addr = i_addr; a.size = i_size; a.strb = 8'h00; a.wdata = 64'h0;
      end
      if (a.who != 2'd0) begin
        lat = (mode == 1) ? 0 : (mode == 3) ? 3 : int'($urandom_range(0, 3));
        a.g = cyc; a.r = cyc + 1 + lat; a.rdata = {$urandom, $urandom};
        cur_g = a.g; cur_r = a.r; cur_rdata = a.rdata;
        next_arb = cyc + 3 + lat;
        acc_q.push_back(a);
      end
    end
  endtask

  // Monitor: pops the expected access when it should appear on the bus
  acc_t cur;
  bit   have_cur = 1'b0;
  always @(negedge clk) begin
    bit exp_mv, exp_rdy;
    if (rst) begin
      have_cur = 1'b0;
    end else begin
      if (acc_q.size() > 0 && acc_q[0].g + 1 == cyc) begin
        cur = acc_q.pop_front();
        have_cur = 1'b1;
        if (mode == 1) hold_log.push_back(owner);
      end
      exp_mv  = have_cur && (cyc <= cur.r);
      exp_rdy = exp_mv && (cyc == cur.r);
      chk("m_valid", m_valid, exp_mv);
      chk("owner", owner, exp_mv ? cur.who : 2'd0);
      if (exp_mv)
        chk("m_payload", {m_is_write, m_addr, m_size, m_strobe, (cur.who == 2'd2) ? m_wdata : 64'h0},
            {cur.w, cur.addr, cur.size, cur.strb, (cur.who == 2'd2) ? cur.wdata : 64'h0});
      chk("i_ready", i_ready, exp_rdy && cur.who == 2'd1);
      chk("d_ready", d_ready, exp_rdy && cur.who == 2'd2);
      if (exp_rdy && cur.who == 2'd1) chk("i_data", i_data, cur.rdata);
      if (exp_rdy && cur.who == 2'd2) chk("d_rdata", d_rdata, cur.rdata);
      if (have_cur && cyc >= cur.r) have_cur = 1'b0;
    end
  end

  initial begin
    logic [1:0] pat [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    int g0;
    rst = 1'b1; i_valid = 0; i_addr = 0; i_size = 0; d_valid = 0; d_addr = 0; d_size = 0;
    d_strobe = 0; d_wdata = 0; m_ready = 1'b1; m_rdata = '1;
    #2;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_ready", {i_ready, d_ready}, 2'b00);
    chk("rst_payload", {m_is_write, m_addr, m_size, m_strobe, m_wdata}, '0);
    step(1); step(1);

    mode = 0;
    for (int k = 0; k < 3000; k++) step(0);

    // Reset while a dbus access is on the bus
    mode = 3; g0 = -1;
    for (int k = 0; k < 20 && g0 < 0; k++) begin
      step(0);
      if (cur_g == cyc) g0 = cyc;
    end
    if (g0 < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL reset_setup: no dbus grant within 20 cycles, got none expected one");
    end
    mode = 2;
    step(0);
    step(1);
    #1;
    chk("rst_mid_m_valid", m_valid, 1'b0);
    chk("rst_mid_owner", owner, 2'd0);
    chk("rst_mid_d_ready", d_ready, 1'b0);
    step(1);
    for (int k = 0; k < 8; k++) step(0);

    // Both requesters held, memory always ready at once
    hold_log.delete();
    mode = 1;
    for (int k = 0; k < 40; k++) step(0);
    mode = 2;
    for (int k = 0; k < 6; k++) step(0);
    if (hold_log.size() < 10) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_order_len: got %0d grants expected at least 10", hold_log.size());
    end else begin
      for (int k = 0; k < 10; k++) chk($sformatf("grant_order[%0d]", k), hold_log[k], pat[k]);
    end

    mode = 0;
    for (int k = 0; k < 1000; k++) step(0);
    mode = 2;
    for (int k = 0; k < 10; k++) step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
